// File: rtl/mem_stage_access.sv
// mem_stage_access -- MEM pipeline stage.
// Takes the EX/MEM register outputs and performs the data-memory access for
// loads and stores over a req/ack bus. While an access is in flight the
// upstream stages are frozen. The result is registered into MEM/WB.
// Non-memory instructions pass through with one cycle of latency.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wd_sel_i, rf_we_i, dram_we_i  control from EX/MEM
//   wR_i, wD_i, alu_c_i, rD2_i    dest reg, ALU data, address, store data
//   pc_i, have_inst_i             instruction PC and valid
//   bus_req_o/we_o/addr_o/wdata_o data bus request side
//   bus_ack_i, bus_rdata_i        data bus completion side
//   mem_stall_o                   combinational freeze of IF..EX/MEM
//   bus_err_o                     sticky ack-timeout flag
//   rf_we_o, wR_o, wD_o, pc_o,
//   have_inst_o                   MEM/WB register outputs
module mem_stage_access #(
   parameter logic [1:0]  WD_SEL_DRAM = 2'b01,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wd_sel_i,
   input  logic        rf_we_i,
   input  logic        dram_we_i,
   input  logic [4:0]  wR_i,
   input  logic [31:0] wD_i,
   input  logic [31:0] alu_c_i,
   input  logic [31:0] rD2_i,
   input  logic [31:0] pc_i,
   input  logic        have_inst_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        mem_stall_o,
   output logic        bus_err_o,
   output logic        rf_we_o,
   output logic [4:0]  wR_o,
   output logic [31:0] wD_o,
   output logic [31:0] pc_o,
   output logic        have_inst_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [31:0] rbuf;
   logic        st, ld, acc;
   logic        timeout;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   // Store wins when both the store flag and the DRAM writeback select are set.
   always_comb begin
      st          = have_inst_i & dram_we_i;
      ld          = have_inst_i & ~dram_we_i & (wd_sel_i == WD_SEL_DRAM);
      acc         = st | ld;
      timeout     = (state == BUSY) & ~bus_ack_i & (cnt == CNT_LAST);
      bus_req_o   = (state == BUSY);
      mem_stall_o = ((state == IDLE) & acc) | (state == BUSY);
      state_nxt   = state;
      case (state)
         IDLE:    if (acc) state_nxt = BUSY;
         BUSY:    if (bus_ack_i || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rbuf        <= '0;
         bus_err_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (acc) begin
                  bus_addr_o  <= alu_c_i;
                  bus_wdata_o <= rD2_i;
                  bus_we_o    <= st;
                  cnt         <= '0;
               end
            end
            BUSY: begin
               if (bus_ack_i) begin
                  rbuf <= bus_rdata_i;
               end else if (timeout) begin
                  rbuf      <= '0;
                  bus_err_o <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // MEM/WB register. In DONE the EX/MEM inputs still hold the memory
   // instruction, so the latched bus direction identifies a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_o     <= 1'b0;
         wR_o        <= '0;
         wD_o        <= '0;
         pc_o        <= '0;
         have_inst_o <= 1'b0;
      end else if (mem_stall_o) begin
         rf_we_o     <= 1'b0;
         have_inst_o <= 1'b0;
      end else begin
         rf_we_o     <= rf_we_i;
         wR_o        <= wR_i;
         pc_o        <= pc_i;
         have_inst_o <= have_inst_i;
         wD_o        <= ((state == DONE) && !bus_we_o) ? rbuf : wD_i;
      end
   end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: table of single-cycle pass-through
// vectors plus hand-written load/store/timeout/reset sequences.
module tb_mem_stage_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wd_sel_i;
   logic        rf_we_i, dram_we_i, have_inst_i;
   logic [4:0]  wR_i;
   logic [31:0] wD_i, alu_c_i, rD2_i, pc_i;
   logic        bus_req_o, bus_we_o, bus_ack_i;
   logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic        mem_stall_o, bus_err_o, rf_we_o, have_inst_o;
   logic [4:0]  wR_o;
   logic [31:0] wD_o, pc_o;

   int tests = 0;
   int fails = 0;

   mem_stage_access #(.WD_SEL_DRAM(2'b01), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .wd_sel_i(wd_sel_i), .rf_we_i(rf_we_i), .dram_we_i(dram_we_i),
      .wR_i(wR_i), .wD_i(wD_i), .alu_c_i(alu_c_i), .rD2_i(rD2_i),
      .pc_i(pc_i), .have_inst_i(have_inst_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .mem_stall_o(mem_stall_o), .bus_err_o(bus_err_o),
      .rf_we_o(rf_we_o), .wR_o(wR_o), .wD_o(wD_o), .pc_o(pc_o),
      .have_inst_o(have_inst_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        have;
      logic [1:0]  sel;
      logic        rf_we;
      logic        dwe;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        e_rf_we;
      logic [4:0]  e_wr;
      logic [31:0] e_wd;
      logic        e_have;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic have, input logic [1:0] sel, input logic rf_we,
                           input logic dwe, input logic [4:0] wr, input logic [31:0] wd,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] pc);
      have_inst_i = have; wd_sel_i = sel; rf_we_i = rf_we; dram_we_i = dwe;
      wR_i = wr; wD_i = wd; alu_c_i = addr; rD2_i = sdata; pc_i = pc;
   endtask

   // Runs an already-presented access from IDLE until mem_stall_o falls.
   // ack_at = BUSY cycle (1-based) in which to strobe ack; 0 = never.
   task automatic run_access(input int ack_at, input logic [31:0] rdata,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata,
                             output int stalls, output int busy);
      stalls = 0;
      busy   = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mem_stall_o) break;
         stalls++;
         if (bus_req_o) begin
            busy++;
            check("busy_we", {31'b0, bus_we_o}, {31'b0, e_we});
            check("busy_addr", bus_addr_o, e_addr);
            check("busy_wdata", bus_wdata_o, e_wdata);
            check("busy_have_o", {31'b0, have_inst_o}, 32'd0);
            if (busy == ack_at) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = rdata;
            end
         end
         tick();
         bus_ack_i   = 1'b0;
         bus_rdata_i = 32'h0BAD_0BAD;
      end
      if (mem_stall_o) check("access_bound", 32'd1, 32'd0);
   endtask

   int stalls, busy;

   initial begin
      vecs[0] = '{1'b1, 2'd0, 1'b1, 1'b0, 5'd5,  32'h0000_1234, 32'h10, 1'b1, 5'd5,  32'h0000_1234, 1'b1};
      vecs[1] = '{1'b1, 2'd2, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h14, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
      vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h18, 1'b0, 5'd0,  32'h0000_0000, 1'b1};
      vecs[3] = '{1'b0, 2'd1, 1'b1, 1'b0, 5'd3,  32'h0000_0077, 32'h1C, 1'b1, 5'd3,  32'h0000_0077, 1'b0};
      vecs[4] = '{1'b0, 2'd0, 1'b0, 1'b1, 5'd4,  32'h0000_0088, 32'h20, 1'b0, 5'd4,  32'h0000_0088, 1'b0};
      vecs[5] = '{1'b1, 2'd3, 1'b1, 1'b0, 5'd12, 32'hABCD_0000, 32'h24, 1'b1, 5'd12, 32'hABCD_0000, 1'b1};

      rst = 1'b1;
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      set_inst(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      #12;
      check("rst_req", {31'b0, bus_req_o}, 32'd0);
      check("rst_stall", {31'b0, mem_stall_o}, 32'd0);
      check("rst_err", {31'b0, bus_err_o}, 32'd0);
      check("rst_have_o", {31'b0, have_inst_o}, 32'd0);
      check("rst_wd_o", wD_o, 32'd0);
      check("rst_addr", bus_addr_o, 32'd0);
      tick();
      rst = 1'b0;

      // Pass-through table, including have_inst=0 entries that must not start an access.
      for (int i = 0; i < 6; i++) begin
         set_inst(vecs[i].have, vecs[i].sel, vecs[i].rf_we, vecs[i].dwe, vecs[i].wr,
                  vecs[i].wd, 32'h300, 32'h5555, vecs[i].pc);
         #1;
         check("vec_stall", {31'b0, mem_stall_o}, 32'd0);
         tick();
         check("vec_req", {31'b0, bus_req_o}, 32'd0);
         check("vec_rf_we", {31'b0, rf_we_o}, {31'b0, vecs[i].e_rf_we});
         check("vec_wR", {27'b0, wR_o}, {27'b0, vecs[i].e_wr});
         check("vec_wD", wD_o, vecs[i].e_wd);
         check("vec_pc", pc_o, vecs[i].pc);
         check("vec_have", {31'b0, have_inst_o}, {31'b0, vecs[i].e_have});
      end

      // Ack while idle is ignored.
      set_inst(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h28);
      bus_ack_i = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      check("idle_ack_req", {31'b0, bus_req_o}, 32'd0);
      check("idle_ack_stall", {31'b0, mem_stall_o}, 32'd0);

      // Load, ack in first BUSY cycle, followed directly by an ALU op.
      set_inst(1'b1, 2'd1, 1'b1, 1'b0, 5'd7, 32'h1111_1111, 32'h100, 32'h2222, 32'h40);
      #1;
      check("ld_stall_idle", {31'b0, mem_stall_o}, 32'd1);
      run_access(1, 32'hCAFE_F00D, 1'b0, 32'h100, 32'h2222, stalls, busy);
      check("ld_stall_cycles", stalls, 32'd2);
      check("ld_busy_cycles", busy, 32'd1);
      check("ld_done_have_o", {31'b0, have_inst_o}, 32'd0);
      tick();
      check("ld_have_o", {31'b0, have_inst_o}, 32'd1);
      check("ld_rf_we_o", {31'b0, rf_we_o}, 32'd1);
      check("ld_wR_o", {27'b0, wR_o}, 32'd7);
      check("ld_wD_o", wD_o, 32'hCAFE_F00D);
      check("ld_pc_o", pc_o, 32'h40);
      set_inst(1'b1, 2'd0, 1'b1, 1'b0, 5'd9, 32'h0000_0055, 32'h0, 32'h0, 32'h44);
      #1;
      check("b2b_stall", {31'b0, mem_stall_o}, 32'd0);
      tick();
      check("b2b_have_o", {31'b0, have_inst_o}, 32'd1);
      check("b2b_wR_o", {27'b0, wR_o}, 32'd9);
      check("b2b_wD_o", wD_o, 32'h0000_0055);
      check("b2b_pc_o", pc_o, 32'h44);

      // Store, ack after three wait cycles.
      set_inst(1'b1, 2'd0, 1'b0, 1'b1, 5'd2, 32'h0000_DEAD, 32'h200, 32'hA5A5_A5A5, 32'h48);
      #1;
      run_access(4, 32'h7777_7777, 1'b1, 32'h200, 32'hA5A5_A5A5, stalls, busy);
      check("st_stall_cycles", stalls, 32'd5);
      check("st_busy_cycles", busy, 32'd4);
      tick();
      check("st_have_o", {31'b0, have_inst_o}, 32'd1);
      check("st_wD_o", wD_o, 32'h0000_DEAD);
      check("st_pc_o", pc_o, 32'h48);
      check("st_err", {31'b0, bus_err_o}, 32'd0);
      set_inst(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h4C);
      tick();
      check("st_no_dup", {31'b0, have_inst_o}, 32'd0);

      // Load with no ack: timeout after 16 BUSY cycles.
      set_inst(1'b1, 2'd1, 1'b1, 1'b0, 5'd10, 32'h9999_9999, 32'h400, 32'h0, 32'h50);
      #1;
      run_access(0, 32'h0, 1'b0, 32'h400, 32'h0, stalls, busy);
      check("to_busy_cycles", busy, 32'd16);
      check("to_stall_cycles", stalls, 32'd17);
      check("to_err", {31'b0, bus_err_o}, 32'd1);
      tick();
      check("to_have_o", {31'b0, have_inst_o}, 32'd1);
      check("to_wD_o", wD_o, 32'd0);
      check("to_wR_o", {27'b0, wR_o}, 32'd10);
      set_inst(1'b1, 2'd0, 1'b1, 1'b0, 5'd11, 32'h0000_00AB, 32'h0, 32'h0, 32'h54);
      tick();
      check("to_resume_wD", wD_o, 32'h0000_00AB);
      check("to_err_sticky", {31'b0, bus_err_o}, 32'd1);

      // Asynchronous reset in the middle of BUSY.
      set_inst(1'b1, 2'd1, 1'b1, 1'b0, 5'd13, 32'h0, 32'h500, 32'h0, 32'h58);
      tick();
      check("rb_req_before", {31'b0, bus_req_o}, 32'd1);
      #2;
      rst = 1'b1;
      have_inst_i = 1'b0;
      #1;
      check("rb_req", {31'b0, bus_req_o}, 32'd0);
      check("rb_stall", {31'b0, mem_stall_o}, 32'd0);
      check("rb_have_o", {31'b0, have_inst_o}, 32'd0);
      check("rb_err", {31'b0, bus_err_o}, 32'd0);
      check("rb_wD_o", wD_o, 32'd0);
      check("rb_addr", bus_addr_o, 32'd0);
      tick();
      rst = 1'b0;
      set_inst(1'b1, 2'd1, 1'b1, 1'b0, 5'd14, 32'h0, 32'h600, 32'h0, 32'h5C);
      #1;
      run_access(2, 32'h1357_9BDF, 1'b0, 32'h600, 32'h0, stalls, busy);
      check("rb_ld_stalls", stalls, 32'd3);
      tick();
      check("rb_ld_have_o", {31'b0, have_inst_o}, 32'd1);
      check("rb_ld_wD_o", wD_o, 32'h1357_9BDF);
      check("rb_ld_err", {31'b0, bus_err_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
